// File: rtl/pipeline_hazard_ctrl.sv
// Hazard control for the ID/EX boundary: detects load-use and taken-branch hazards,
// sequences one-cycle stalls and multi-cycle flushes, and keeps saturating event counters.
module pipeline_hazard_ctrl #(
  parameter int FLUSH_DEPTH = 1,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [10:0]      EX_control_words,
  input  logic [14:0]      EX_rs_rt_rd,
  input  logic [4:0]       ID_rs,
  input  logic [4:0]       ID_rt,
  input  logic             ID_uses_rt,
  input  logic             branch_taken,
  output logic             pc_write_en,
  output logic             if_id_write_en,
  output logic             if_id_flush,
  output logic             id_ex_bubble,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_cycles
);

  typedef enum logic [1:0] {RUN, LU_STALL, FLUSH} state_t;

  localparam logic [2:0] FLUSH_INIT = 3'(FLUSH_DEPTH - 1);

  state_t     state, state_nxt;
  logic [2:0] flush_left, flush_left_nxt;
  logic       stall_evt, flush_evt;
  logic [4:0] ex_rt;
  logic       ex_mem_read;
  logic       load_use;

  assign ex_rt       = EX_rs_rt_rd[9:5];
  assign ex_mem_read = EX_control_words[7];
  assign load_use    = ex_mem_read && (ex_rt != 5'd0) &&
                       ((ex_rt == ID_rs) || (ID_uses_rt && (ex_rt == ID_rt)));

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= RUN;
      flush_left   <= 3'd0;
      stall_cycles <= '0;
      flush_cycles <= '0;
    end else begin
      state      <= state_nxt;
      flush_left <= flush_left_nxt;
      if (stall_evt && (stall_cycles != '1)) stall_cycles <= stall_cycles + CNT_W'(1);
      if (flush_evt && (flush_cycles != '1)) flush_cycles <= flush_cycles + CNT_W'(1);
    end
  end

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt      = state;
    flush_left_nxt = flush_left;
    stall_evt      = 1'b0;
    flush_evt      = 1'b0;
    unique case (state)
      RUN, LU_STALL: begin
        if (branch_taken) begin
          flush_evt = 1'b1;
          if (FLUSH_DEPTH > 1) begin
            state_nxt      = FLUSH;
            flush_left_nxt = FLUSH_INIT;
          end else begin
            state_nxt = RUN;
          end
        end else if ((state == RUN) && load_use) begin
          // In LU_STALL, EX already holds the bubble, so the old match is stale.
          stall_evt = 1'b1;
          state_nxt = LU_STALL;
        end else begin
          state_nxt = RUN;
        end
      end
      FLUSH: begin
        flush_evt      = 1'b1;
        flush_left_nxt = flush_left - 3'd1;
        if (flush_left == 3'd1) state_nxt = RUN;
      end
      default: begin
        state_nxt      = RUN;
        flush_left_nxt = 3'd0;
      end
    endcase
  end

  always_comb begin
    pc_write_en    = 1'b1;
    if_id_write_en = 1'b1;
    if_id_flush    = 1'b0;
    id_ex_bubble   = 1'b0;
    if (!rst_n) begin
      pc_write_en    = 1'b0;
      if_id_write_en = 1'b0;
      if_id_flush    = 1'b1;
      id_ex_bubble   = 1'b1;
    end else begin
      unique case (state)
        RUN, LU_STALL: begin
          if (branch_taken) begin
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
          end else if ((state == RUN) && load_use) begin
            pc_write_en    = 1'b0;
            if_id_write_en = 1'b0;
            id_ex_bubble   = 1'b1;
          end
        end
        FLUSH: begin
          if_id_flush  = 1'b1;
          id_ex_bubble = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
